// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package instr_loader_pkg;

  localparam int WORD_BYTES = 4;
  localparam int IMEM_DEPTH = 64;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    CHECK   = 3'd3,
    DONE    = 3'd4
  } state_t;

  // A request longer than the memory is cut to the memory size.
  function automatic logic [6:0] clamp_len(input logic [6:0] req, input logic [6:0] depth);
    return (req > depth) ? depth : req;
  endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and memory write port of the loader.
// master: the loader side (accepts bytes, drives the write cycle).
// slave:  the environment side (byte source + instruction memory).
interface instr_mem_loader_if;

  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [31:0] a;
  logic [31:0] wd;
  logic        we;

  modport master (
    input  byte_in, byte_valid,
    output byte_ready, a, wd, we
  );

  modport slave (
    output byte_in, byte_valid,
    input  byte_ready, a, wd, we
  );

endinterface

// File: rtl/instr_mem_loader_byte_packer.sv
// Little-endian byte-to-word packer: byte k of a word lands in bits [8k+7:8k].
// word_out already contains the byte being accepted this cycle, so the owner
// can latch the finished word on the same edge that word_full is seen.
module byte_packer
  import instr_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        accept,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        word_full
);

  localparam int CW = $clog2(WORD_BYTES);

  logic [CW-1:0] cnt;
  logic [31:0]   word_q;

  // Merge the incoming byte into the partially assembled word.
  always_comb begin
    word_out = word_q;
    if (accept) word_out[{cnt, 3'b000} +: 8] = byte_in;
  end

  assign word_full = accept && (cnt == CW'(WORD_BYTES - 1));

  // Byte counter wraps naturally after the last byte of a word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      word_q <= '0;
    end else if (clear) begin
      cnt    <= '0;
      word_q <= '0;
    end else if (accept) begin
      cnt    <= cnt + 1'b1;
      word_q <= word_out;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction-memory loader: packs a byte stream into words, writes them to
// consecutive word addresses and holds the CPU in reset while doing so.
// Optional trailing checksum word: define INSTR_LOADER_CHECKSUM_EN.
//
// state   | meaning
// IDLE    | waiting for start after reset
// COLLECT | accepting the 4 bytes of the next word
// WRITE   | single write cycle, byte input stalled
// CHECK   | accepting the checksum word (checksum build only)
// DONE    | load complete, waiting for the next start
module instr_mem_loader
  import instr_loader_pkg::*;
#(
  parameter int          DEPTH     = IMEM_DEPTH,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [6:0]         load_len,
  instr_mem_loader_if.master bus,
  output logic               busy,
  output logic               done,
  output logic               cpu_hold,
  output logic               chk_err
);

  localparam int         IW      = $clog2(DEPTH);
  localparam logic [6:0] DEPTH_L = 7'(DEPTH);

  state_t        state;
  logic [6:0]    len;
  logic [IW-1:0] idx;
  logic          start_ok;
  logic          accept;
  logic          word_full;
  logic [31:0]   word_out;

  assign start_ok = start && ((state == IDLE) || (state == DONE));
  assign accept   = bus.byte_valid && bus.byte_ready;
  assign cpu_hold = busy;

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .accept    (accept),
    .clear     (start_ok),
    .byte_in   (bus.byte_in),
    .word_out  (word_out),
    .word_full (word_full)
  );

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [31:0] sum;
`else
  assign chk_err = 1'b0;
`endif

  // Load sequencer; every output is a register so the memory sees clean strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      len            <= '0;
      idx            <= '0;
      bus.byte_ready <= 1'b0;
      bus.we         <= 1'b0;
      bus.a          <= '0;
      bus.wd         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      sum            <= '0;
      chk_err        <= 1'b0;
`endif
    end else begin
      bus.we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            len  <= clamp_len(load_len, DEPTH_L);
            idx  <= '0;
            done <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            sum     <= '0;
            chk_err <= 1'b0;
`endif
            if (load_len == 7'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state          <= COLLECT;
              busy           <= 1'b1;
              bus.byte_ready <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (word_full) begin
            state          <= WRITE;
            bus.byte_ready <= 1'b0;
            bus.we         <= 1'b1;
            bus.a          <= BASE_ADDR + (32'(idx) << 2);
            bus.wd         <= word_out;
`ifdef INSTR_LOADER_CHECKSUM_EN
            sum            <= sum + word_out;
`endif
          end
        end
        WRITE: begin
          if ((7'(idx) + 7'd1) == len) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
            state          <= CHECK;
            bus.byte_ready <= 1'b1;
`else
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
`endif
          end else begin
            idx            <= idx + 1'b1;
            state          <= COLLECT;
            bus.byte_ready <= 1'b1;
          end
        end
        CHECK: begin
`ifdef INSTR_LOADER_CHECKSUM_EN
          if (word_full) begin
            chk_err        <= (word_out != sum);
            state          <= DONE;
            done           <= 1'b1;
            busy           <= 1'b0;
            bus.byte_ready <= 1'b0;
          end
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
